// File: rtl/ccm_pkg.sv
// Shared CCM burst-port encodings and writer FSM states.
// Used by ofmap_writer and the kernel/fmap reader blocks.
package ccm_pkg;

  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned MAX_BURST = 8;

  localparam logic [3:0]  MEM_CMD_IDLE = 4'h0;
  localparam int unsigned MEM_CMD_WR   = 3;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_CFG  = 3'd1;
  localparam logic [ST_W-1:0] ST_CALC      = 3'd2;
  localparam logic [ST_W-1:0] ST_FILL      = 3'd3;
  localparam logic [ST_W-1:0] ST_GRANT_REQ = 3'd4;
  localparam logic [ST_W-1:0] ST_CMD       = 3'd5;
  localparam logic [ST_W-1:0] ST_XFER      = 3'd6;
  localparam logic [ST_W-1:0] ST_ADVANCE   = 3'd7;

  typedef enum logic [ST_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD_CFG  = ST_LOAD_CFG,
    S_CALC      = ST_CALC,
    S_FILL      = ST_FILL,
    S_GRANT_REQ = ST_GRANT_REQ,
    S_CMD       = ST_CMD,
    S_XFER      = ST_XFER,
    S_ADVANCE   = ST_ADVANCE
  } state_e;

  // Write command for a burst of 'words' 32-bit beats (1..MAX_BURST)
  function automatic logic [3:0] mem_wr_cmd(input logic [3:0] words);
    logic [3:0] cmd;
    cmd             = MEM_CMD_IDLE;
    cmd[MEM_CMD_WR] = 1'b1;
    cmd[2:0]        = 3'(words - 4'd1);
    return cmd;
  endfunction

endpackage

// File: rtl/simple_fifo_16to32.sv
// Halfword-in / word-out FIFO: pairs 16-bit writes into 32-bit words
// (first halfword in [15:0]), flush pads an odd tail with zeros.
module simple_fifo_16to32
  import ccm_pkg::*;
#(
  parameter  int unsigned DEPTH = MAX_BURST,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [15:0]   wr_data_i,
  input  logic          flush_i,
  input  logic          rd_i,
  output logic [31:0]   rd_data_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [15:0]      lo_q;
  logic             half_q;

  logic             push_c;
  logic             pop_c;
  logic [31:0]      push_word_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Word completes on the second halfword or on a flush of a pending halfword
  always_comb begin
    push_c      = 1'b0;
    push_word_c = {16'h0000, lo_q};
    if (wr_i && half_q) begin
      push_c      = 1'b1;
      push_word_c = {wr_data_i, lo_q};
    end else if (flush_i && half_q && !wr_i) begin
      push_c = 1'b1;
    end
    if (count_q == CW'(DEPTH)) push_c = 1'b0;
  end

  assign pop_c     = rd_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage, pointers, pending-halfword register
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lo_q     <= '0;
      half_q   <= 1'b0;
    end else begin
      if (wr_i) begin
        if (half_q) begin
          half_q <= 1'b0;
        end else begin
          lo_q   <= wr_data_i;
          half_q <= 1'b1;
        end
      end else if (flush_i) begin
        half_q <= 1'b0;
      end
      if (push_c) begin
        mem_q[wr_ptr_q] <= push_word_c;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// Output-feature-map writer: packs 16-bit pixels into 32-bit words and
// writes them to CCM memory in bursts of up to MAX_BURST words.
// Optional build macro: OFMAP_RELU_EN (negative pixels stored as zero).
module ofmap_writer
  import ccm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_start,
  output logic        OfmapWRWork,
  input  logic [15:0] PIX_IN,
  input  logic        PIX_VLD,
  output logic        PIX_RDY,
  input  logic [31:0] CFG_OFMAP_START_ADDR,
  input  logic [9:0]  CFG_OFMAP_SIZE,
  input  logic [9:0]  CFG_NUM_KERN,
  output logic        CCM_REQ,
  input  logic        MEM_CCM_SEL,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_CMD,
  output logic [31:0] MEM_DOUT,
  input  logic        MEM_WR_RDY,
  input  logic        MEM_FIN
);

  localparam int unsigned HW_W   = $clog2(2 * MAX_BURST + 1);
  localparam int unsigned WD_W   = $clog2(MAX_BURST + 1);
  localparam int unsigned PROD_W = 30;
  localparam logic [CNT_W-1:0] BURST_HW_MAX = CNT_W'(2 * MAX_BURST);

  state_e            state_q;
  logic [CNT_W-1:0]  left_q;
  logic [31:0]       addr_q;
  logic [HW_W-1:0]   burst_hw_q;
  logic [HW_W-1:0]   hw_cnt_q;
  logic [WD_W-1:0]   words_q;
  logic              pix_rdy_q;
  logic              ccm_req_q;
  logic              work_q;
  logic [3:0]        mem_cmd_q;

  logic [PROD_W-1:0] total_c;
  logic [HW_W-1:0]   hw_c;
  logic              pix_xfer_c;
  logic              last_pix_c;
  logic [15:0]       pix_c;
  logic              fifo_clr_c;
  logic              fifo_flush_c;
  logic              fifo_rd_c;
  logic [31:0]       fifo_head;
  logic [WD_W-1:0]   fifo_count;

  assign total_c = PROD_W'(CFG_OFMAP_SIZE) * PROD_W'(CFG_OFMAP_SIZE) * PROD_W'(CFG_NUM_KERN);
  assign hw_c    = (left_q >= BURST_HW_MAX) ? HW_W'(2 * MAX_BURST) : HW_W'(left_q);

  assign pix_xfer_c   = PIX_VLD && pix_rdy_q;
  assign last_pix_c   = pix_xfer_c && (hw_cnt_q == burst_hw_q - HW_W'(1));
  // FILL with PIX_RDY low is the one-cycle tail where an odd halfword is padded out
  assign fifo_flush_c = (state_q == S_FILL) && !pix_rdy_q;
  assign fifo_clr_c   = (state_q == S_LOAD_CFG);
  assign fifo_rd_c    = (state_q == S_XFER) && MEM_WR_RDY && (fifo_count != '0);

  // Optional ReLU on accepted pixels; timing is unaffected
  always_comb begin
    pix_c = PIX_IN;
`ifdef OFMAP_RELU_EN
    if (PIX_IN[15]) pix_c = 16'h0000;
`else
    pix_c = PIX_IN;
`endif
  end

  simple_fifo_16to32 #(
    .DEPTH (MAX_BURST)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (fifo_clr_c),
    .wr_i      (pix_xfer_c),
    .wr_data_i (pix_c),
    .flush_i   (fifo_flush_c),
    .rd_i      (fifo_rd_c),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count)
  );

  // Burst sequencer; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      left_q     <= '0;
      addr_q     <= '0;
      burst_hw_q <= '0;
      hw_cnt_q   <= '0;
      words_q    <= '0;
      pix_rdy_q  <= 1'b0;
      ccm_req_q  <= 1'b0;
      mem_cmd_q  <= MEM_CMD_IDLE;
      work_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_start) begin
            state_q <= S_LOAD_CFG;
            work_q  <= 1'b1;
          end
        end
        S_LOAD_CFG: begin
          left_q  <= CNT_W'(total_c);
          addr_q  <= CFG_OFMAP_START_ADDR;
          state_q <= S_CALC;
        end
        S_CALC: begin
          // An empty job is caught here, once the product has been registered
          if (left_q == '0) begin
            state_q <= S_IDLE;
            work_q  <= 1'b0;
          end else begin
            burst_hw_q <= hw_c;
            words_q    <= WD_W'((hw_c + HW_W'(1)) >> 1);
            left_q     <= left_q - CNT_W'(hw_c);
            hw_cnt_q   <= '0;
            pix_rdy_q  <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        S_FILL: begin
          if (pix_rdy_q) begin
            if (pix_xfer_c) hw_cnt_q <= hw_cnt_q + HW_W'(1);
            if (last_pix_c) pix_rdy_q <= 1'b0;
          end else begin
            ccm_req_q <= 1'b1;
            mem_cmd_q <= mem_wr_cmd(4'(words_q));
            state_q   <= S_GRANT_REQ;
          end
        end
        S_GRANT_REQ: begin
          if (MEM_CCM_SEL) state_q <= S_CMD;
        end
        S_CMD: begin
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (MEM_FIN) begin
            ccm_req_q <= 1'b0;
            mem_cmd_q <= MEM_CMD_IDLE;
            state_q   <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          addr_q <= addr_q + (32'(words_q) << 2);
          if (left_q == '0) begin
            state_q <= S_IDLE;
            work_q  <= 1'b0;
          end else begin
            state_q <= S_CALC;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign OfmapWRWork = work_q;
  assign PIX_RDY     = pix_rdy_q;
  assign CCM_REQ     = ccm_req_q;
  assign MEM_CMD     = mem_cmd_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_DOUT    = fifo_head;

endmodule

// File: tb/tb_ofmap_writer.sv
// Bench for ofmap_writer: job table driven through a bench-side memory/pixel
// model, packed words scoreboarded in a queue, plus hand-written corner cases.
module tb_ofmap_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_start;
  logic        OfmapWRWork;
  logic [15:0] PIX_IN;
  logic        PIX_VLD;
  logic        PIX_RDY;
  logic [31:0] CFG_OFMAP_START_ADDR;
  logic [9:0]  CFG_OFMAP_SIZE;
  logic [9:0]  CFG_NUM_KERN;
  logic        CCM_REQ;
  logic        MEM_CCM_SEL;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_CMD;
  logic [31:0] MEM_DOUT;
  logic        MEM_WR_RDY;
  logic        MEM_FIN;

  int total = 0;
  int bad   = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [9:0]  sz;
    logic [9:0]  nk;
    logic [31:0] start;
    int          grant_dly;
    bit          rdy_toggle;
    bit          vld_gaps;
    logic [15:0] pbase;
    int          exp_bursts;
    logic [31:0] exp_end_addr;
  } job_t;

  job_t jobs [7];

  ofmap_writer dut (
    .clk                  (clk),
    .rst                  (rst),
    .op_start             (op_start),
    .OfmapWRWork          (OfmapWRWork),
    .PIX_IN               (PIX_IN),
    .PIX_VLD              (PIX_VLD),
    .PIX_RDY              (PIX_RDY),
    .CFG_OFMAP_START_ADDR (CFG_OFMAP_START_ADDR),
    .CFG_OFMAP_SIZE       (CFG_OFMAP_SIZE),
    .CFG_NUM_KERN         (CFG_NUM_KERN),
    .CCM_REQ              (CCM_REQ),
    .MEM_CCM_SEL          (MEM_CCM_SEL),
    .MEM_ADDR             (MEM_ADDR),
    .MEM_CMD              (MEM_CMD),
    .MEM_DOUT             (MEM_DOUT),
    .MEM_WR_RDY           (MEM_WR_RDY),
    .MEM_FIN              (MEM_FIN)
  );

  always #5 clk = ~clk;

  // Counts bus-request rising edges as seen on the port
  always @(posedge clk) begin
    req_prev <= CCM_REQ;
    if (CCM_REQ && !req_prev) req_rises <= req_rises + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] relu_m(input logic [15:0] v);
`ifdef OFMAP_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Drives one job end to end; abort_beat >= 0 resets the DUT mid-XFER
  task automatic run_job(input job_t j, input int abort_beat);
    int unsigned left, hw, words, acc, pidx, n;
    int          rises0;
    logic [31:0] addr, dout0, e;
    logic [3:0]  ecmd;
    logic [15:0] lo, v;
    bit          ok, ph;
    rises0 = req_rises;
    CFG_OFMAP_SIZE       = j.sz;
    CFG_NUM_KERN         = j.nk;
    CFG_OFMAP_START_ADDR = j.start;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    chk("work_after_start", 32'(OfmapWRWork), 32'd1);
    step();
    chk("rdy_in_calc", 32'(PIX_RDY), 32'd0);
    step();
    chk("first_pix_latency", 32'(PIX_RDY), 32'd1);
    left = int'(j.sz) * int'(j.sz) * int'(j.nk);
    addr = j.start;
    pidx = 0;
    lo   = 16'h0;
    while (left > 0) begin
      hw    = (left > 16) ? 16 : left;
      words = (hw + 1) / 2;
      left  = left - hw;
      ecmd  = {1'b1, 3'(words - 1)};
      acc = 0;
      n   = 0;
      while (acc < hw && n < 200) begin
        v = j.pbase + 16'(pidx);
        PIX_IN  = v;
        PIX_VLD = !(j.vld_gaps && ($urandom_range(0, 2) == 0));
        if (PIX_VLD && PIX_RDY) begin
          if (acc % 2 == 0) begin
            lo = relu_m(v);
            if (acc == hw - 1) exp_q.push_back({16'h0000, lo});
          end else begin
            exp_q.push_back({relu_m(v), lo});
          end
          acc++;
          pidx++;
        end
        step();
        n++;
      end
      if (acc < hw) chk("fill_timeout", acc, hw);
      chk("rdy_drop", 32'(PIX_RDY), 32'd0);
      // upstream keeps offering the next pixel while the burst is written
      PIX_VLD = (left > 0);
      PIX_IN  = j.pbase + 16'(pidx);

      n = 0;
      while (!CCM_REQ && n < 8) begin
        step();
        n++;
      end
      chk("req_latency", n, 32'd1);
      chk("cmd", 32'(MEM_CMD), 32'(ecmd));
      chk("addr", MEM_ADDR, addr);
      ok    = 1'b1;
      dout0 = MEM_DOUT;
      for (int k = 0; k < j.grant_dly; k++) begin
        op_start = (k == 3);
        step();
        op_start = 1'b0;
        if (CCM_REQ !== 1'b1 || MEM_CMD !== ecmd || MEM_DOUT !== dout0 ||
            PIX_RDY !== 1'b0 || MEM_ADDR !== addr) ok = 1'b0;
      end
      if (j.grant_dly > 0) chk("grant_wait_stable", 32'(ok), 32'd1);

      MEM_CCM_SEL = 1'b1;
      step();
      MEM_CCM_SEL = 1'b0;
      chk("cmd_state", 32'({CCM_REQ, MEM_CMD}), 32'({1'b1, ecmd}));
      step();

      acc = 0;
      n   = 0;
      ph  = 1'b1;
      ok  = 1'b1;
      while (acc < words && n < 100) begin
        if (abort_beat >= 0 && acc == abort_beat) begin
          MEM_WR_RDY = 1'b0;
          PIX_VLD    = 1'b0;
          rst        = 1'b1;
          step();
          rst = 1'b0;
          chk("rst_xfer_bus", 32'({CCM_REQ, MEM_CMD, OfmapWRWork, PIX_RDY}), 32'd0);
          chk("rst_xfer_dout", MEM_DOUT, 32'd0);
          chk("rst_xfer_addr", MEM_ADDR, 32'd0);
          step();
          chk("rst_xfer_idle", 32'({CCM_REQ, OfmapWRWork}), 32'd0);
          exp_q.delete();
          return;
        end
        MEM_WR_RDY = j.rdy_toggle ? ph : 1'b1;
        ph = !ph;
        if (MEM_WR_RDY) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("dout", MEM_DOUT, e);
          end
          acc++;
        end
        if (CCM_REQ !== 1'b1 || MEM_CMD !== ecmd || PIX_RDY !== 1'b0) ok = 1'b0;
        step();
        n++;
      end
      if (acc < words) chk("xfer_timeout", acc, words);
      MEM_WR_RDY = 1'b0;
      MEM_FIN    = 1'b1;
      step();
      MEM_FIN = 1'b0;
      chk("xfer_stable", 32'(ok), 32'd1);
      chk("advance_bus_idle", 32'({CCM_REQ, MEM_CMD}), 32'd0);
      addr = addr + 32'(4 * words);
    end
    PIX_VLD = 1'b0;
    step();
    chk("work_done", 32'(OfmapWRWork), 32'd0);
    chk("end_addr", MEM_ADDR, j.exp_end_addr);
    chk("burst_count", 32'(req_rises - rises0), 32'(j.exp_bursts));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (OfmapWRWork !== 1'b0 || CCM_REQ !== 1'b0) ok = 1'b0;
    end
    chk("stays_idle", 32'(ok), 32'd1);
  endtask

  initial begin
    int hi;
    bit req_seen;
    //          sz     nk     start          gnt tog gap pbase      bursts end_addr
    jobs[0] = '{10'd2, 10'd1, 32'h0000_0100,  0, 0,  0,  16'h0001, 1, 32'h0000_0108};
    jobs[1] = '{10'd5, 10'd1, 32'h0000_2000,  0, 0,  0,  16'h1000, 2, 32'h0000_2034};
    jobs[2] = '{10'd3, 10'd2, 32'h0000_4000, 20, 0,  0,  16'h0A00, 2, 32'h0000_4024};
    jobs[3] = '{10'd4, 10'd1, 32'h0000_6000,  2, 1,  0,  16'h0300, 1, 32'h0000_6020};
    jobs[4] = '{10'd2, 10'd3, 32'hFFFF_FFF0,  1, 1,  1,  16'hFFF8, 1, 32'h0000_0008};
    jobs[5] = '{10'd2, 10'd1, 32'h0000_0300,  0, 0,  1,  16'h7FFE, 1, 32'h0000_0308};
    jobs[6] = '{10'd3, 10'd1, 32'h0000_0500,  3, 1,  1,  16'h8001, 1, 32'h0000_0514};

    rst = 1'b1;
    op_start = 1'b0;
    PIX_IN = 16'h0;
    PIX_VLD = 1'b0;
    CFG_OFMAP_START_ADDR = 32'h0;
    CFG_OFMAP_SIZE = 10'd0;
    CFG_NUM_KERN = 10'd0;
    MEM_CCM_SEL = 1'b0;
    MEM_WR_RDY = 1'b0;
    MEM_FIN = 1'b0;
    repeat (3) step();
    chk("reset_ctrl", 32'({OfmapWRWork, PIX_RDY, CCM_REQ, MEM_CMD}), 32'd0);
    chk("reset_addr", MEM_ADDR, 32'd0);
    chk("reset_dout", MEM_DOUT, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_job(jobs[i], -1);

    // Empty job: busy for LOAD_CFG and CALC only, no request, restart ignored
    CFG_OFMAP_SIZE = 10'd0;
    CFG_NUM_KERN   = 10'd7;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    hi = 0;
    req_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (OfmapWRWork) hi++;
      if (CCM_REQ) req_seen = 1'b1;
      op_start = (k == 0);
      step();
    end
    op_start = 1'b0;
    chk("zero_size_busy_cycles", 32'(hi), 32'd2);
    chk("zero_size_no_req", 32'(req_seen), 32'd0);

    // Reset in the middle of a transfer, then a clean rerun
    run_job(jobs[1], 1);
    run_job(jobs[0], -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
